op_scheduler: RTL and testbench
===============================

# op_scheduler

Arbitrating sequencer in front of the polynomial operation datapath (forward/inverse NTT, pointwise multiply, add, sub). Two requesters, e.g. the keygen/sign control FSM and the verify control FSM, submit commands over valid/ready ports. The block grants one command at a time using round-robin arbitration, pulses the datapath start, and holds mode/encode_mode stable for the whole operation. It routes the completion back to the originating requester, with illegal-mode rejection and a timeout watchdog that resets the datapath on a hang.

## Interface
- TAG_W, 4: width of requester-supplied command tag echoed in response
- TIMEOUT, 4095: max cycles from op_start to op_done before abort (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester command valid (bit 0 = requester A, bit 1 = B)
- req_ready  out  2  per-requester command accepted (combinational, one-hot or zero)
- req_mode_a / req_mode_b  in  3  operation code (0 FNTT, 1 INTT, 2 MULT, 3 ADD, 4 SUB)
- req_enc_a / req_enc_b  in  2  encode_mode for the datapath
- req_tag_a / req_tag_b  in  TAG_W  opaque tag
- rsp_valid  out  2  one-cycle completion pulse to the originating requester
- rsp_err  out  1  qualifies rsp_valid: 1 = illegal mode or timeout
- rsp_tag  out  TAG_W  tag of the completed command
- op_start  out  1  one-cycle start pulse to datapath
- op_mode  out  3  datapath mode, stable from op_start until completion
- op_enc  out  2  datapath encode_mode, same stability rule
- op_rst  out  1  active-high synchronous reset to datapath, one-cycle pulse on timeout
- op_done  in  1  datapath one-cycle done pulse
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, START, BUSY, RESP, ABORT.
- IDLE: arbiter picks among asserted req_valid. On conflict, the requester not granted last wins (last_grant register, reset → B, so A wins first tie). The winner's req_ready goes high. On the handshake, capture mode/enc/tag/requester id.
  - Captured mode 0–4 → START.
  - Captured mode 5–7 → RESP with err=1; no op_start issued.
- START: op_start=1 for one cycle; load watchdog counter with 0 → BUSY.
- BUSY: counter increments each cycle.
  - op_done → RESP with err=0.
  - Counter reaches TIMEOUT−1 with no op_done → ABORT.
- ABORT: op_rst=1 for one cycle → RESP with err=1.
- RESP: rsp_valid[id]=1 and rsp_tag/rsp_err valid for one cycle; update last_grant=id → IDLE.
- op_mode/op_enc are registered. They change only on acceptance and hold until the next acceptance; the datapath decodes mode combinationally, so mode must not glitch mid-op.
- op_done outside BUSY is ignored.
- req_ready is 0 in every state except IDLE. No command queueing; requesters hold valid until ready.

## Timing
- Reset (async assert, sync-released by clk): state IDLE; req_ready=0 while rst_n low; rsp_valid=0, rsp_err=0, rsp_tag=0, op_start=0, op_mode=0, op_enc=0, op_rst=0, busy=0, last_grant=B, counter=0.
- Handshake in cycle t → op_start in t+1 → busy from t+1.
- op_done in cycle d → rsp_valid in d+1 → IDLE in d+2. Earliest next acceptance is d+2, so back-to-back ops have a 3-cycle overhead.
- Illegal mode: accept at t → rsp_valid(err) at t+1.
- Timeout: op_start at s, no done → op_rst at s+TIMEOUT+1, rsp_valid(err) at s+TIMEOUT+2.
- op_done arriving the same cycle the counter hits TIMEOUT−1: done wins (err=0, no op_rst).
- Reset mid-operation: everything returns to reset values immediately; no rsp pulse is emitted; op_rst is not pulsed (the datapath shares the system reset).

## Structure
- Shared package (dilithium_pkg): mode localparams FORWARD_NTT_MODE=0 … SUB_MODE=4, MODE_W=3, ENC_W=2, and the FSM state encoding.
- One sub-module, rr_arbiter2: 2-way round-robin, inputs req[1:0] and last_grant, output grant one-hot. Combinational, instantiated once.
- Counter width is $clog2(TIMEOUT+1).

## Test plan
- Single op: A sends mode=2, enc=0, tag=5; model asserts op_done 100 cycles after start → op_start one cycle after accept, op_mode=2 held throughout, rsp_valid=2'b01, tag=5, err=0.
- Contention: A and B both valid in IDLE after reset → A granted first, then B on the next IDLE; with both held continuously, grants alternate A,B,A,B.
- Illegal mode: B sends mode=6, tag=3 → no op_start, rsp_valid=2'b10 one cycle after accept, err=1, tag=3.
- Timeout: TIMEOUT=16, no op_done → op_rst pulse 17 cycles after op_start, then rsp err=1; a late op_done is ignored.
- Done/timeout collision: op_done on the final counter cycle → err=0, no op_rst.
- Async reset asserted in BUSY → all outputs 0 without clk edge; after release, a new A command completes normally.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared definitions for the polynomial-op scheduler: operation codes,
// field widths, FSM state encoding and requester identifiers.
package dilithium_pkg;

    localparam int MODE_W = 3;
    localparam int ENC_W  = 2;

    localparam logic [MODE_W-1:0] FORWARD_NTT_MODE = 3'd0;
    localparam logic [MODE_W-1:0] INVERSE_NTT_MODE = 3'd1;
    localparam logic [MODE_W-1:0] MULT_MODE        = 3'd2;
    localparam logic [MODE_W-1:0] ADD_MODE         = 3'd3;
    localparam logic [MODE_W-1:0] SUB_MODE         = 3'd4;

    // Requester identity as stored in the fairness pointer and response routing.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_RESP  = 3'd3,
        S_ABORT = 3'd4
    } sched_state_e;

    // Codes above SUB_MODE have no datapath meaning and are rejected.
    function automatic logic mode_is_legal(input logic [MODE_W-1:0] mode);
        return (mode <= SUB_MODE);
    endfunction

endpackage

// File: rtl/op_scheduler_if.sv
// Requester command/response ports and datapath control ports of the
// scheduler, bundled so checkers can bind to one object.
//
// Handshake: a command transfers on a rising clk edge where req_valid[i] and
// req_ready[i] are both 1. A requester raises req_valid[i] with its mode/enc/tag
// stable and holds all of them until that edge; req_ready never depends on a
// transfer being in flight and is at most one-hot.
interface op_scheduler_if #(
    parameter int TAG_W = 4
) ();
    import dilithium_pkg::*;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [MODE_W-1:0] req_mode_a;
    logic [MODE_W-1:0] req_mode_b;
    logic [ENC_W-1:0]  req_enc_a;
    logic [ENC_W-1:0]  req_enc_b;
    logic [TAG_W-1:0]  req_tag_a;
    logic [TAG_W-1:0]  req_tag_b;

    logic [1:0]        rsp_valid;
    logic              rsp_err;
    logic [TAG_W-1:0]  rsp_tag;

    logic              op_start;
    logic [MODE_W-1:0] op_mode;
    logic [ENC_W-1:0]  op_enc;
    logic              op_rst;
    logic              op_done;

    logic              busy;
    sched_state_e      state_dbg;

    // Scheduler side.
    modport slave (
        input  req_valid, req_mode_a, req_mode_b, req_enc_a, req_enc_b,
               req_tag_a, req_tag_b, op_done,
        output req_ready, rsp_valid, rsp_err, rsp_tag,
               op_start, op_mode, op_enc, op_rst, busy, state_dbg
    );

    // Requesters plus datapath side.
    modport master (
        output req_valid, req_mode_a, req_mode_b, req_enc_a, req_enc_b,
               req_tag_a, req_tag_b, op_done,
        input  req_ready, rsp_valid, rsp_err, rsp_tag,
               op_start, op_mode, op_enc, op_rst, busy, state_dbg
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright; on a tie the
// requester that was not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Pick the winner from the request pair and the fairness pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/op_scheduler.sv
// Arbitrating sequencer for the polynomial datapath: accepts one command at
// a time from two requesters, starts the datapath, watches for a hang and
// routes the completion back to whoever issued the command.
module op_scheduler
    import dilithium_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          rst_n,
    op_scheduler_if.slave bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [ENC_W-1:0]  enc_q, enc_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              id_q, id_d;
    logic              err_q, err_d;
    logic              last_grant_q, last_grant_d;

    logic [1:0]        grant;
    logic [1:0]        ready;
    logic              accept;
    logic [MODE_W-1:0] sel_mode;
    logic [ENC_W-1:0]  sel_enc;
    logic [TAG_W-1:0]  sel_tag;

    rr_arbiter2 u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Ready only in IDLE and never while reset is held, so nothing is taken
    // on the edge that releases reset unless the requester still wants it.
    assign ready  = (state_q == S_IDLE && rst_n) ? grant : 2'b00;
    assign accept = |ready;

    // Mux the winning requester's command fields.
    always_comb begin
        sel_mode = bus.req_mode_a;
        sel_enc  = bus.req_enc_a;
        sel_tag  = bus.req_tag_a;
        if (grant[1]) begin
            sel_mode = bus.req_mode_b;
            sel_enc  = bus.req_enc_b;
            sel_tag  = bus.req_tag_b;
        end
    end

    // Next-state logic: capture on acceptance, run the watchdog, pick the outcome.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        enc_d        = enc_q;
        tag_d        = tag_q;
        id_d         = id_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mode_d = sel_mode;
                    enc_d  = sel_enc;
                    tag_d  = sel_tag;
                    id_d   = grant[1] ? REQ_B : REQ_A;
                    if (mode_is_legal(sel_mode)) begin
                        err_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done on the last watchdog cycle still counts as success.
                if (bus.op_done) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                err_d   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                last_grant_d = id_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and captured command; async reset returns to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mode_q       <= '0;
            enc_q        <= '0;
            tag_q        <= '0;
            id_q         <= REQ_A;
            err_q        <= 1'b0;
            last_grant_q <= REQ_B;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            enc_q        <= enc_d;
            tag_q        <= tag_d;
            id_q         <= id_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output decode; response fields read zero outside RESP.
    always_comb begin
        bus.req_ready = ready;
        bus.op_start  = (state_q == S_START);
        bus.op_rst    = (state_q == S_ABORT);
        bus.op_mode   = mode_q;
        bus.op_enc    = enc_q;
        bus.busy      = (state_q != S_IDLE);
        bus.state_dbg = state_q;
        bus.rsp_valid = 2'b00;
        bus.rsp_err   = 1'b0;
        bus.rsp_tag   = '0;
        if (state_q == S_RESP) begin
            bus.rsp_valid = (id_q == REQ_B) ? 2'b10 : 2'b01;
            bus.rsp_err   = err_q;
            bus.rsp_tag   = tag_q;
        end
    end

endmodule

// File: tb/tb_op_scheduler.sv
// Testbench for op_scheduler: directed scenarios plus randomized commands,
// checked against a cycle-offset model of each command's outcome.
module tb_op_scheduler;
    import dilithium_pkg::*;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    op_scheduler_if #(.TAG_W(TAG_W)) bus ();

    op_scheduler #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [TAG_W+2:0] exp_q[$];   // {rsp_valid, rsp_err, rsp_tag}
    logic lg_m;                   // model: last granted requester, 1 = B

    logic [MODE_W-1:0] mode_a, mode_b;
    logic [ENC_W-1:0]  enc_a, enc_b;
    logic [TAG_W-1:0]  tag_a, tag_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Fairness rule: a lone requester wins; on a tie the one not served last wins.
    function automatic logic [1:0] model_grant(input logic [1:0] mask, input logic last_b);
        if (mask == 2'b11) return last_b ? 2'b01 : 2'b10;
        return mask;
    endfunction

    // ---------------- driver: one command from IDLE to its response ----------------
    // done_dly: cycles from op_start to the op_done pulse (0 = never).
    task automatic run_cmd(input logic [1:0] mask, input int done_dly);
        logic [1:0]        g;
        logic [MODE_W-1:0] m;
        logic [ENC_W-1:0]  e;
        logic [TAG_W-1:0]  t;
        logic              legal;
        logic              exp_err;
        int                rsp_rel;
        int                rst_rel;
        logic [TAG_W+2:0]  got_rsp;
        logic [TAG_W+2:0]  exp_rsp;

        g     = model_grant(mask, lg_m);
        m     = g[1] ? mode_b : mode_a;
        e     = g[1] ? enc_b  : enc_a;
        t     = g[1] ? tag_b  : tag_a;
        legal = (m <= 3'd4);

        // Outcome timing relative to the acceptance cycle.
        if (!legal) begin
            rsp_rel = 1;
            rst_rel = -1;
        end else if (done_dly >= 1 && done_dly <= TIMEOUT) begin
            rsp_rel = done_dly + 2;
            rst_rel = -1;
        end else begin
            rst_rel = TIMEOUT + 2;
            rsp_rel = TIMEOUT + 3;
        end
        exp_err = !legal || (rst_rel > 0);
        exp_q.push_back({g, exp_err, t});

        bus.req_valid  = mask;
        bus.req_mode_a = mode_a;
        bus.req_mode_b = mode_b;
        bus.req_enc_a  = enc_a;
        bus.req_enc_b  = enc_b;
        bus.req_tag_a  = tag_a;
        bus.req_tag_b  = tag_b;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("ready", 32'(bus.req_ready), 32'(g));
        @(posedge clk);
        #1;
        bus.req_valid = mask & ~g;

        for (int rel = 1; rel <= rsp_rel; rel++) begin
            bus.op_done = legal && (done_dly > 0) && (rel == done_dly + 1);
            @(negedge clk);
            check("op_start", 32'(bus.op_start), 32'(legal && rel == 1));
            check("op_rst", 32'(bus.op_rst), 32'(rel == rst_rel));
            check("op_mode", 32'(bus.op_mode), 32'(m));
            check("op_enc", 32'(bus.op_enc), 32'(e));
            check("busy", 32'(bus.busy), 32'd1);
            check("ready_low", 32'(bus.req_ready), 32'd0);
            if (rel == rsp_rel) begin
                got_rsp = {bus.rsp_valid, bus.rsp_err, bus.rsp_tag};
                exp_rsp = exp_q.pop_front();
                check("rsp", 32'(got_rsp), 32'(exp_rsp));
            end else begin
                check("rsp_quiet", 32'(bus.rsp_valid), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        bus.op_done = 1'b0;
        lg_m = g[1];
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int dly;
        logic [1:0] mask;

        bus.req_valid  = 2'b11;
        bus.req_mode_a = '0;
        bus.req_mode_b = '0;
        bus.req_enc_a  = '0;
        bus.req_enc_b  = '0;
        bus.req_tag_a  = '0;
        bus.req_tag_b  = '0;
        bus.op_done    = 1'b0;
        lg_m           = 1'b1;

        // Reset values, with both requesters asking.
        #12;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_outs", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_tag, bus.op_start,
                               bus.op_mode, bus.op_enc, bus.op_rst, bus.busy}), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention straight after reset: A, B, A, B.
        mode_a = 3'd0; enc_a = 2'd1; tag_a = 4'd1;
        mode_b = 3'd1; enc_b = 2'd2; tag_b = 4'd2;
        for (int i = 0; i < 4; i++) run_cmd(2'b11, 3 + i);

        // Single op: A, MULT, tag 5.
        mode_a = 3'd2; enc_a = 2'd0; tag_a = 4'd5;
        run_cmd(2'b01, 10);

        // Illegal mode from B.
        mode_b = 3'd6; enc_b = 2'd1; tag_b = 4'd3;
        run_cmd(2'b10, 0);

        // Timeout with a late done landing in ABORT.
        mode_a = 3'd3; enc_a = 2'd3; tag_a = 4'd9;
        run_cmd(2'b01, TIMEOUT + 1);

        // Done on the final watchdog cycle; then the earliest possible done.
        mode_b = 3'd4; enc_b = 2'd2; tag_b = 4'd12;
        run_cmd(2'b10, TIMEOUT);
        run_cmd(2'b10, 1);

        // Randomized commands.
        for (int i = 0; i < 30; i++) begin
            mask   = 2'($urandom_range(1, 3));
            mode_a = 3'($urandom_range(0, 7));
            mode_b = 3'($urandom_range(0, 7));
            enc_a  = 2'($urandom_range(0, 3));
            enc_b  = 2'($urandom_range(0, 3));
            tag_a  = 4'($urandom_range(0, 15));
            tag_b  = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r == 0)      dly = 0;
            else if (r == 1) dly = TIMEOUT;
            else if (r == 2) dly = TIMEOUT + 1;
            else             dly = $urandom_range(1, TIMEOUT - 1);
            run_cmd(mask, dly);
        end

        // Async reset in the middle of a BUSY op.
        mode_a = 3'd1; enc_a = 2'd3; tag_a = 4'd7;
        bus.req_valid  = 2'b01;
        bus.req_mode_a = mode_a;
        bus.req_enc_a  = enc_a;
        bus.req_tag_a  = tag_a;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_outs", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_tag, bus.op_start,
                                   bus.op_mode, bus.op_enc, bus.op_rst, bus.busy}), 32'd0);
        check("mid_rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        lg_m  = 1'b1;
        @(posedge clk);
        #1;
        mode_a = 3'd2; enc_a = 2'd1; tag_a = 4'd11;
        mode_b = 3'd3; enc_b = 2'd0; tag_b = 4'd4;
        run_cmd(2'b11, 6);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Run-time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
